// File: rtl/uram_2w2r_fwd_if.sv
// Request/response bundle for both ports of uram_2w2r_fwd, plus the collision
// flag and the optional collision-counter signals.
interface uram_2w2r_fwd_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                  ce0;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] rdata0;
  logic                  rvalid0;
  logic                  ce1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic [DATA_WIDTH-1:0] rdata1;
  logic                  rvalid1;
  logic                  ww_cflt;
  logic                  cnt_clr;
  logic [15:0]           cflt_cnt;

  modport master (
    output ce0, we0, addr0, wdata0, ce1, we1, addr1, wdata1, cnt_clr,
    input  rdata0, rvalid0, rdata1, rvalid1, ww_cflt, cflt_cnt
  );

  modport slave (
    input  ce0, we0, addr0, wdata0, ce1, we1, addr1, wdata1, cnt_clr,
    output rdata0, rvalid0, rdata1, rvalid1, ww_cflt, cflt_cnt
  );
endinterface

// File: rtl/uram_2w2r_fwd.sv
// True dual-port common-clock RAM with write-first cross-port forwarding,
// configurable read latency and write-write collision flag.
// Optional saturating collision counter: define URAM_2W2R_CFLT_CNT_EN.
module uram_2w2r_fwd #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned WW_PRIORITY  = 0
) (
  input  logic              clk,
  input  logic              rst,
  uram_2w2r_fwd_if.slave    s
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("uram_2w2r_fwd: READ_LATENCY must be in 1..4");
  end
  if (WW_PRIORITY > 1) begin : g_bad_priority
    $error("uram_2w2r_fwd: WW_PRIORITY must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  ce     [2];
  logic                  we     [2];
  logic                  wr     [2];
  logic [ADDR_WIDTH-1:0] addr   [2];
  logic [DATA_WIDTH-1:0] wdata  [2];
  logic [DATA_WIDTH-1:0] rdata  [2];
  logic                  rvalid [2];
  logic                  ww_hit;
  logic                  ww_cflt_q;
  logic                  ww_cflt_d;

  assign ce[0]    = s.ce0;
  assign ce[1]    = s.ce1;
  assign we[0]    = s.we0;
  assign we[1]    = s.we1;
  assign addr[0]  = s.addr0;
  assign addr[1]  = s.addr1;
  assign wdata[0] = s.wdata0;
  assign wdata[1] = s.wdata1;
  assign wr[0]    = ce[0] & we[0];
  assign wr[1]    = ce[1] & we[1];
  assign ww_hit   = wr[0] & wr[1] & (addr[0] == addr[1]);

  // On a same-address double write only the priority port's word is stored.
  always_ff @(posedge clk) begin
    if (wr[0] && !(ww_hit && WW_PRIORITY == 1)) mem[addr[0]] <= wdata[0];
    if (wr[1] && !(ww_hit && WW_PRIORITY == 0)) mem[addr[1]] <= wdata[1];
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    localparam int O = 1 - p;

    logic [READ_LATENCY-1:0]                 vld_q;
    logic [READ_LATENCY-1:0]                 vld_d;
    logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] dat_q;
    logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] dat_d;
    logic [DATA_WIDTH-1:0]                   cap;

    // Data stages only advance behind a valid entry, so the last stage
    // keeps the most recent read word while rvalid is low.
    always_comb begin
      cap      = (wr[O] && addr[O] == addr[p]) ? wdata[O] : mem[addr[p]];
      vld_d    = '0;
      dat_d    = dat_q;
      vld_d[0] = ce[p] & ~we[p];
      if (vld_d[0]) dat_d[0] = cap;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= '0;
        dat_q <= '0;
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end

    assign rvalid[p] = vld_q[READ_LATENCY-1];
    assign rdata[p]  = dat_q[READ_LATENCY-1];
  end

  always_comb begin
    ww_cflt_d = ww_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ww_cflt_q <= 1'b0;
    else     ww_cflt_q <= ww_cflt_d;
  end

  assign s.rdata0  = rdata[0];
  assign s.rvalid0 = rvalid[0];
  assign s.rdata1  = rdata[1];
  assign s.rvalid1 = rvalid[1];
  assign s.ww_cflt = ww_cflt_q;

`ifdef URAM_2W2R_CFLT_CNT_EN
  logic [15:0] cflt_cnt_q;
  logic [15:0] cflt_cnt_d;

  always_comb begin
    cflt_cnt_d = cflt_cnt_q;
    if (s.cnt_clr)                         cflt_cnt_d = '0;
    else if (ww_cflt_q && cflt_cnt_q != '1) cflt_cnt_d = cflt_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cflt_cnt_q <= '0;
    else     cflt_cnt_q <= cflt_cnt_d;
  end

  assign s.cflt_cnt = cflt_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = s.cnt_clr;
  assign s.cflt_cnt     = '0;
`endif

endmodule

// File: tb/tb_uram_2w2r_fwd.sv
// Self-checking bench for uram_2w2r_fwd: directed cases plus random traffic
// compared every cycle against a queue/array reference model.
module tb_uram_2w2r_fwd;

  localparam int unsigned DW  = 64;
  localparam int unsigned AW  = 12;
  localparam int unsigned LAT = 2;
  localparam int unsigned WWP = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uram_2w2r_fwd_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  uram_2w2r_fwd #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .READ_LATENCY(LAT),
    .WW_PRIORITY (WWP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s  (bus)
  );

  typedef struct {
    bit          v;
    logic [DW-1:0] d;
  } ent_t;

  int checks = 0;
  int errors = 0;
  int pulses0 = 0;
  int pulses1 = 0;

  logic [DW-1:0] mem_m [1<<AW];
  ent_t          q0[$];
  ent_t          q1[$];
  logic [DW-1:0] e_rd0, e_rd1;
  bit            e_rv0, e_rv1, e_ww;
  logic [15:0]   e_cnt;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ent_t z;
    z.v = 1'b0;
    z.d = '0;
    q0.delete();
    q1.delete();
    for (int i = 0; i < int'(LAT) - 1; i++) begin
      q0.push_back(z);
      q1.push_back(z);
    end
    e_rd0 = '0; e_rd1 = '0;
    e_rv0 = 1'b0; e_rv1 = 1'b0;
    e_ww  = 1'b0;
    e_cnt = '0;
  endtask

  // Applies one clock edge's worth of the behavioural rules to the model.
  task automatic model_step();
    ent_t n0, n1, o0, o1;
    bit   wr0, wr1;
    if (rst) begin
      model_reset();
      return;
    end
    wr0  = bus.ce0 && bus.we0;
    wr1  = bus.ce1 && bus.we1;
    n0.v = bus.ce0 && !bus.we0;
    n0.d = (wr1 && bus.addr1 == bus.addr0) ? bus.wdata1 : mem_m[bus.addr0];
    n1.v = bus.ce1 && !bus.we1;
    n1.d = (wr0 && bus.addr0 == bus.addr1) ? bus.wdata0 : mem_m[bus.addr1];
    q0.push_back(n0);
    q1.push_back(n1);
    o0 = q0.pop_front();
    o1 = q1.pop_front();
    e_rv0 = o0.v;
    e_rv1 = o1.v;
    if (o0.v) e_rd0 = o0.d;
    if (o1.v) e_rd1 = o1.d;
`ifdef URAM_2W2R_CFLT_CNT_EN
    if (bus.cnt_clr)                   e_cnt = '0;
    else if (e_ww && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
`endif
    e_ww = wr0 && wr1 && bus.addr0 == bus.addr1;
    if (e_ww) begin
      mem_m[bus.addr0] = (WWP == 1) ? bus.wdata1 : bus.wdata0;
    end else begin
      if (wr0) mem_m[bus.addr0] = bus.wdata0;
      if (wr1) mem_m[bus.addr1] = bus.wdata1;
    end
  endtask

  task automatic step(bit c0, bit w0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                      bit c1, bit w1, logic [AW-1:0] a1, logic [DW-1:0] d1,
                      bit clr = 1'b0);
    bus.ce0 = c0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.ce1 = c1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    bus.cnt_clr = clr;
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  always @(negedge clk) begin
    chk("rvalid0", {63'd0, bus.rvalid0}, {63'd0, e_rv0});
    chk("rdata0", bus.rdata0, e_rd0);
    chk("rvalid1", {63'd0, bus.rvalid1}, {63'd0, e_rv1});
    chk("rdata1", bus.rdata1, e_rd1);
    chk("ww_cflt", {63'd0, bus.ww_cflt}, {63'd0, e_ww});
    chk("cflt_cnt", {48'd0, bus.cflt_cnt}, {48'd0, e_cnt});
    if (bus.rvalid0) pulses0++;
    if (bus.rvalid1) pulses1++;
  end

  initial begin
    int p0s, p1s;
    rst = 1'b1;
    bus.ce0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.ce1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    bus.cnt_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_rdata0", bus.rdata0, 64'd0);
    chk("rst_rvalid0", {63'd0, bus.rvalid0}, 64'd0);
    chk("rst_rvalid1", {63'd0, bus.rvalid1}, 64'd0);
    chk("rst_ww_cflt", {63'd0, bus.ww_cflt}, 64'd0);
    chk("rst_cflt_cnt", {48'd0, bus.cflt_cnt}, 64'd0);
    rst = 1'b0;

    // Preload 0x000..0x0FF so every later read has a defined value.
    for (int k = 0; k < 128; k++)
      step(1'b1, 1'b1, AW'(2*k), {$urandom, $urandom},
           1'b1, 1'b1, AW'(2*k+1), {$urandom, $urandom});

    // Write then cross-port read, latency and single-cycle rvalid.
    step(1'b1, 1'b1, 12'h010, 64'hA5, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h010, '0);
    idle();
    chk("t1_rdata1", bus.rdata1, 64'hA5);
    chk("t1_rvalid1", {63'd0, bus.rvalid1}, 64'd1);
    idle();
    chk("t1_rvalid1_off", {63'd0, bus.rvalid1}, 64'd0);

    // Write-first forwarding to the other port in the same cycle.
    step(1'b1, 1'b1, 12'h020, 64'h11, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b1, 12'h020, 64'h22, 1'b1, 1'b0, 12'h020, '0);
    step(1'b1, 1'b0, 12'h020, '0, 1'b0, 1'b0, '0, '0);
    chk("t2_fwd_rdata1", bus.rdata1, 64'h22);
    idle();
    chk("t2_rdata0", bus.rdata0, 64'h22);

    // Write-write collision.
    step(1'b1, 1'b1, 12'h030, 64'h33, 1'b1, 1'b1, 12'h030, 64'h44);
    chk("t3_ww_on", {63'd0, bus.ww_cflt}, 64'd1);
    idle();
    chk("t3_ww_off", {63'd0, bus.ww_cflt}, 64'd0);
    step(1'b1, 1'b0, 12'h030, '0, 1'b0, 1'b0, '0, '0);
    idle();
    chk("t3_winner", bus.rdata0, (WWP == 1) ? 64'h44 : 64'h33);

    // A later write must not disturb a read already in flight.
    step(1'b1, 1'b1, 12'h040, 64'h55, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 12'h040, '0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'h040, 64'h66);
    chk("t4_inflight", bus.rdata0, 64'h55);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h040, '0);
    idle();
    chk("t4_after", bus.rdata1, 64'h66);

    // Random mixed traffic on a small address window.
    for (int k = 0; k < 600; k++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom_range(0, 15)),
           {$urandom, $urandom},
           1'($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom_range(0, 15)),
           {$urandom, $urandom}, 1'($urandom_range(0, 7) == 0));
    repeat (4) idle();

    // Full-throughput read burst on both ports.
    p0s = pulses0;
    p1s = pulses1;
    for (int i = 0; i < 256; i++)
      step(1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(255 - i), '0);
    repeat (LAT + 1) idle();
    chk("burst_pulses0", 64'(pulses0 - p0s), 64'd256);
    chk("burst_pulses1", 64'(pulses1 - p1s), 64'd256);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 100; i++)
      step(1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(i), '0);
    chk("pre_rst_rvalid0", {63'd0, bus.rvalid0}, 64'd1);
    bus.ce0 = 1'b0;
    bus.ce1 = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_rvalid0", {63'd0, bus.rvalid0}, 64'd0);
    chk("async_rst_rvalid1", {63'd0, bus.rvalid1}, 64'd0);
    chk("async_rst_rdata1", bus.rdata1, 64'd0);
    #1;
    repeat (2) idle();
    rst = 1'b0;
    repeat (4) idle();
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(i + 7), '0);
    repeat (LAT + 1) idle();

    // Collision counter.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 12'h050, 64'(i), 1'b1, 1'b1, 12'h050, 64'(i + 9));
    repeat (2) idle();
`ifdef URAM_2W2R_CFLT_CNT_EN
    chk("cnt_three", {48'd0, bus.cflt_cnt}, 64'd3);
    step(1'b1, 1'b1, 12'h050, 64'd1, 1'b1, 1'b1, 12'h050, 64'd2);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    chk("cnt_clr_priority", {48'd0, bus.cflt_cnt}, 64'd0);
    idle();
    for (int i = 0; i < 65536; i++)
      step(1'b1, 1'b1, 12'h060, 64'd1, 1'b1, 1'b1, 12'h060, 64'd2);
    repeat (2) idle();
    chk("cnt_saturate", {48'd0, bus.cflt_cnt}, 64'hFFFF);
    step(1'b1, 1'b1, 12'h060, 64'd1, 1'b1, 1'b1, 12'h060, 64'd2);
    repeat (2) idle();
    chk("cnt_hold_max", {48'd0, bus.cflt_cnt}, 64'hFFFF);
`else
    chk("cnt_tied_zero", {48'd0, bus.cflt_cnt}, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
